// File: rtl/ram_ctrl_pkg.sv
// Shared encodings for the RAM ring-buffer controller: FSM states, arbiter
// grant identities and RAM bus direction values.
package ram_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    typedef enum logic {
        GNT_WRITE = 1'b0,
        GNT_READ  = 1'b1
    } grant_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/ram_ring_ctrl_if.sv
// Requester-side bundle of the ring controller: clear pulse, writer and
// reader handshakes, read result and status.
interface ram_ring_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 8
);
    logic             i_clr;
    logic             i_wr_valid;
    logic [WIDTH-1:0] i_wr_data;
    logic             o_wr_ready;
    logic             i_rd_valid;
    logic [ADDR-1:0]  i_rd_offset;
    logic             o_rd_ready;
    logic             o_rd_valid;
    logic [WIDTH-1:0] o_rd_data;
    logic             o_rd_err;
    logic [ADDR:0]    o_count;
    logic             o_busy;

    modport slave (
        input  i_clr, i_wr_valid, i_wr_data, i_rd_valid, i_rd_offset,
        output o_wr_ready, o_rd_ready, o_rd_valid, o_rd_data, o_rd_err,
               o_count, o_busy
    );

    modport master (
        output i_clr, i_wr_valid, i_wr_data, i_rd_valid, i_rd_offset,
        input  o_wr_ready, o_rd_ready, o_rd_valid, o_rd_data, o_rd_err,
               o_count, o_busy
    );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Two-requester round-robin arbiter (writer vs reader). Grants are
// combinational; the last-grant flop decides ties.
module ram_rr_arbiter
    import ram_ctrl_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_req_wr,
    input  logic i_req_rd,
    output logic o_gnt_wr,
    output logic o_gnt_rd
);
    grant_e last_q;
    grant_e last_d;

    // Grant selection and last-grant update
    always_comb begin
        o_gnt_wr = 1'b0;
        o_gnt_rd = 1'b0;
        last_d   = last_q;
        if (i_en) begin
            if (i_req_wr && i_req_rd) begin
                if (last_q == GNT_READ) begin
                    o_gnt_wr = 1'b1;
                end else begin
                    o_gnt_rd = 1'b1;
                end
            end else if (i_req_wr) begin
                o_gnt_wr = 1'b1;
            end else if (i_req_rd) begin
                o_gnt_rd = 1'b1;
            end else begin
                o_gnt_wr = 1'b0;
            end
        end else begin
            o_gnt_wr = 1'b0;
        end
        if (o_gnt_wr) begin
            last_d = GNT_WRITE;
        end else if (o_gnt_rd) begin
            last_d = GNT_READ;
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= GNT_READ;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/ram_ring_ctrl.sv
// Circular history-buffer controller sharing one single-port tristate RAM
// between a sample writer and a history reader, with a full-RAM clear sweep.
module ram_ring_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ADDR  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    ram_ring_ctrl_if.slave     req,
    output logic [ADDR-1:0]    o_ram_addr,
    output logic               o_ram_rw,
    output logic               o_ram_wen,
    inout  wire  [WIDTH-1:0]   io_ram_data
);
    localparam logic [ADDR:0]   DEPTH_C  = {1'b1, {ADDR{1'b0}}};
    localparam logic [ADDR-1:0] ADDR_MAX = {ADDR{1'b1}};
    localparam logic [ADDR-1:0] ADDR_ONE = {{(ADDR-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [ADDR-1:0]  wptr_q, wptr_d;
    logic [ADDR-1:0]  clr_addr_q, clr_addr_d;
    logic [ADDR:0]    count_q, count_d;
    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_err_q;

    logic             arb_en_s, gnt_wr_s, gnt_rd_s, rd_ok_s;
    logic [ADDR-1:0]  rd_addr_s, ram_addr_s;
    logic             ram_rw_s, ram_wen_s;
    logic [WIDTH-1:0] ram_wdata_s;

    assign arb_en_s  = (state_q == ST_IDLE) && !req.i_clr;
    assign rd_ok_s   = ({1'b0, req.i_rd_offset} < count_q);
    assign rd_addr_s = wptr_q - ADDR_ONE - req.i_rd_offset;

    ram_rr_arbiter u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (arb_en_s),
        .i_req_wr (req.i_wr_valid),
        .i_req_rd (req.i_rd_valid),
        .o_gnt_wr (gnt_wr_s),
        .o_gnt_rd (gnt_rd_s)
    );

    // Next-state, pointer/count update and RAM bus control
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        clr_addr_d  = clr_addr_q;
        ram_addr_s  = wptr_q;
        ram_rw_s    = RW_READ;
        ram_wen_s   = 1'b0;
        ram_wdata_s = req.i_wr_data;
        case (state_q)
            ST_IDLE: begin
                if (req.i_clr) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = {ADDR{1'b0}};
                end else if (gnt_wr_s) begin
                    ram_rw_s  = RW_WRITE;
                    ram_wen_s = 1'b1;
                    wptr_d    = wptr_q + ADDR_ONE;
                    if (count_q == DEPTH_C) begin
                        count_d = count_q;
                    end else begin
                        count_d = count_q + {{ADDR{1'b0}}, 1'b1};
                    end
                end else if (gnt_rd_s && rd_ok_s) begin
                    ram_addr_s = rd_addr_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                ram_addr_s  = clr_addr_q;
                ram_rw_s    = RW_WRITE;
                ram_wen_s   = 1'b1;
                ram_wdata_s = {WIDTH{1'b0}};
                clr_addr_d  = clr_addr_q + ADDR_ONE;
                if (clr_addr_q == ADDR_MAX) begin
                    state_d    = ST_IDLE;
                    wptr_d     = {ADDR{1'b0}};
                    count_d    = {(ADDR+1){1'b0}};
                    clr_addr_d = {ADDR{1'b0}};
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            wptr_q     <= {ADDR{1'b0}};
            count_q    <= {(ADDR+1){1'b0}};
            clr_addr_q <= {ADDR{1'b0}};
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Read result capture; an out-of-range offset returns zero with error set
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= {WIDTH{1'b0}};
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= gnt_rd_s;
            if (gnt_rd_s && rd_ok_s) begin
                rd_data_q <= io_ram_data;
                rd_err_q  <= 1'b0;
            end else if (gnt_rd_s) begin
                rd_data_q <= {WIDTH{1'b0}};
                rd_err_q  <= 1'b1;
            end else begin
                rd_data_q <= rd_data_q;
                rd_err_q  <= rd_err_q;
            end
        end
    end

    assign io_ram_data    = (ram_rw_s == RW_WRITE) ? ram_wdata_s : {WIDTH{1'bz}};
    assign o_ram_addr     = ram_addr_s;
    assign o_ram_rw       = ram_rw_s;
    assign o_ram_wen      = ram_wen_s;
    assign req.o_wr_ready = gnt_wr_s;
    assign req.o_rd_ready = gnt_rd_s;
    assign req.o_rd_valid = rd_valid_q;
    assign req.o_rd_data  = rd_data_q;
    assign req.o_rd_err   = rd_err_q;
    assign req.o_count    = count_q;
    assign req.o_busy     = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_ram_ring_ctrl.sv
// Self-checking bench for ram_ring_ctrl: DEPTH=256 and DEPTH=8 instances,
// each on its own behavioural tristate RAM, checked against a bench model.
module tb_ram_ring_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_ring_ctrl_if #(.WIDTH(8), .ADDR(8)) if8 ();
    ram_ring_ctrl_if #(.WIDTH(8), .ADDR(3)) if3 ();

    logic [7:0] ram_addr8;
    logic [2:0] ram_addr3;
    logic       ram_rw8, ram_wen8, ram_rw3, ram_wen3;
    wire  [7:0] bus8, bus3;
    logic [7:0] mem8 [256];
    logic [7:0] mem3 [8];

    ram_ring_ctrl #(.WIDTH(8), .ADDR(8)) u8 (
        .i_clk(clk), .i_rst_n(rst_n), .req(if8), .o_ram_addr(ram_addr8),
        .o_ram_rw(ram_rw8), .o_ram_wen(ram_wen8), .io_ram_data(bus8));
    ram_ring_ctrl #(.WIDTH(8), .ADDR(3)) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .req(if3), .o_ram_addr(ram_addr3),
        .o_ram_rw(ram_rw3), .o_ram_wen(ram_wen3), .io_ram_data(bus3));

    assign bus8 = (ram_rw8 == 1'b0) ? mem8[ram_addr8] : 8'bzzzzzzzz;
    assign bus3 = (ram_rw3 == 1'b0) ? mem3[ram_addr3] : 8'bzzzzzzzz;
    always @(posedge clk) if (ram_wen8 && ram_rw8) mem8[ram_addr8] <= bus8;
    always @(posedge clk) if (ram_wen3 && ram_rw3) mem3[ram_addr3] <= bus3;

    typedef struct packed { logic [7:0] data; logic err; } exp_t;
    exp_t sb[$];
    logic [7:0] m8 [256];
    logic [7:0] mw8;
    int         mc8;
    int n_cmp = 0;
    int n_err = 0;

    task automatic do_reset();
        if8.i_clr = 1'b0; if8.i_wr_valid = 1'b0; if8.i_rd_valid = 1'b0;
        if8.i_wr_data = 8'h00; if8.i_rd_offset = 8'h00;
        if3.i_clr = 1'b0; if3.i_wr_valid = 1'b0; if3.i_rd_valid = 1'b0;
        if3.i_wr_data = 8'h00; if3.i_rd_offset = 3'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        mw8 = 8'h00; mc8 = 0; sb.delete();
        @(posedge clk); #1;
    endtask

    task automatic wr8(input logic [7:0] d);
        int g = 0;
        if8.i_wr_valid = 1'b1; if8.i_wr_data = d;
        @(negedge clk);
        while (!if8.o_wr_ready && g < 20) begin @(negedge clk); g++; end
        n_cmp++;
        if (!if8.o_wr_ready) begin
            n_err++; $display("FAIL wr8_ready: ready=%b required 1", if8.o_wr_ready);
        end else begin
            m8[mw8] = d; mw8 = mw8 + 8'd1;
            if (mc8 < 256) mc8++;
        end
        @(posedge clk); #1; if8.i_wr_valid = 1'b0;
    endtask

    task automatic rd8(input logic [7:0] off, input string nm);
        exp_t e;
        int g = 0;
        if8.i_rd_valid = 1'b1; if8.i_rd_offset = off;
        @(negedge clk);
        while (!if8.o_rd_ready && g < 20) begin @(negedge clk); g++; end
        n_cmp++;
        if (!if8.o_rd_ready) begin
            n_err++; $display("FAIL %s_ready: never granted", nm);
            if8.i_rd_valid = 1'b0;
            return;
        end
        n_cmp++;
        if (ram_rw8 !== 1'b0) begin
            n_err++; $display("FAIL %s_rw: ram_rw=%b required 0", nm, ram_rw8);
        end
        if (32'(off) < mc8) begin e.data = m8[mw8 - 8'd1 - off]; e.err = 1'b0; end
        else begin e.data = 8'h00; e.err = 1'b1; end
        sb.push_back(e);
        @(posedge clk); #1; if8.i_rd_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (if8.o_rd_valid !== 1'b1) begin
            n_err++; $display("FAIL %s_valid: rd_valid=%b required 1", nm, if8.o_rd_valid);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({if8.o_rd_data, if8.o_rd_err} !== {e.data, e.err}) begin
                n_err++;
                $display("FAIL %s_data: data=%h err=%b required data=%h err=%b",
                         nm, if8.o_rd_data, if8.o_rd_err, e.data, e.err);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({if8.o_count, if8.o_rd_valid, if8.o_rd_data, if8.o_rd_err, if8.o_busy,
             ram_rw8, ram_wen8, ram_addr8} !== {9'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset8: count=%0d rv=%b rd=%h re=%b busy=%b rw=%b wen=%b addr=%h required all zero",
                     if8.o_count, if8.o_rd_valid, if8.o_rd_data, if8.o_rd_err, if8.o_busy,
                     ram_rw8, ram_wen8, ram_addr8);
        end
        n_cmp++;
        if ({if3.o_count, if3.o_busy, ram_addr3} !== {4'd0, 1'b0, 3'd0}) begin
            n_err++; $display("FAIL reset3: count=%0d busy=%b addr=%0d required 0", if3.o_count, if3.o_busy, ram_addr3);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        wr8(8'h11); wr8(8'h22); wr8(8'h33);
        @(negedge clk);
        n_cmp++;
        if (if8.o_count !== 9'd3) begin
            n_err++; $display("FAIL count3: count=%0d required 3", if8.o_count);
        end
        @(posedge clk); #1;
        rd8(8'd0, "rd_off0");
        rd8(8'd2, "rd_off2");
        rd8(8'd1, "rd_off1");
    endtask

    task automatic test_bad_offset();
        rd8(8'd3, "rd_off3_err");
        rd8(8'd200, "rd_off200_err");
        n_cmp++;
        if (if8.o_count !== 9'd3) begin
            n_err++; $display("FAIL count_after_err: count=%0d required 3", if8.o_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g [4];
        exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
        do_reset();
        if8.i_wr_valid = 1'b1; if8.i_rd_valid = 1'b1; if8.i_rd_offset = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if8.i_wr_data = 8'hA0 + 8'(i);
            @(negedge clk);
            n_cmp++;
            if ({if8.o_wr_ready, if8.o_rd_ready} !== exp_g[i]) begin
                n_err++;
                $display("FAIL arb_cycle%0d: wr_ready=%b rd_ready=%b required %b", i,
                         if8.o_wr_ready, if8.o_rd_ready, exp_g[i]);
            end
            if (if8.o_wr_ready) begin
                m8[mw8] = if8.i_wr_data; mw8 = mw8 + 8'd1; mc8++;
            end
            @(posedge clk); #1;
        end
        if8.i_wr_valid = 1'b0; if8.i_rd_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (if8.o_count !== 9'd2) begin
            n_err++; $display("FAIL arb_count: count=%0d required 2", if8.o_count);
        end
        @(posedge clk); #1;
        rd8(8'd0, "arb_rd_newest");
    endtask

    task automatic test_wrap();
        logic [7:0] m3 [8];
        logic [2:0] offs [2];
        exp_t e;
        offs[0] = 3'd0; offs[1] = 3'd7;
        if3.i_wr_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if3.i_wr_data = 8'(i);
            m3[3'(i - 1)] = 8'(i);
            @(posedge clk); #1;
        end
        if3.i_wr_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({if3.o_count, ram_addr3} !== {4'd8, 3'd2}) begin
            n_err++; $display("FAIL wrap_state: count=%0d wptr=%0d required 8 and 2", if3.o_count, ram_addr3);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            if3.i_rd_valid = 1'b1; if3.i_rd_offset = offs[k];
            e.data = m3[3'd2 - 3'd1 - offs[k]]; e.err = 1'b0;
            sb.push_back(e);
            @(posedge clk); #1; if3.i_rd_valid = 1'b0;
            @(negedge clk);
            n_cmp++;
            e = sb.pop_front();
            if ({if3.o_rd_valid, if3.o_rd_data, if3.o_rd_err} !== {1'b1, e.data, e.err}) begin
                n_err++;
                $display("FAIL wrap_rd_off%0d: valid=%b data=%0d err=%b required 1 %0d %b", offs[k],
                         if3.o_rd_valid, if3.o_rd_data, if3.o_rd_err, e.data, e.err);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_clear();
        int busy_n = 0;
        int nz = 0;
        int grants = 0;
        if8.i_clr = 1'b1; if8.i_wr_valid = 1'b1; if8.i_wr_data = 8'h77;
        @(negedge clk);
        n_cmp++;
        if (if8.o_wr_ready !== 1'b0) begin
            n_err++; $display("FAIL clr_priority: wr_ready=%b required 0", if8.o_wr_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        while (if8.o_busy === 1'b1 && busy_n < 300) begin
            busy_n++;
            if (if8.o_wr_ready || if8.o_rd_ready) grants++;
            if (busy_n == 2) if8.i_clr = 1'b1;
            if (busy_n == 3) if8.i_clr = 1'b0;
            if (busy_n == 5) if8.i_wr_valid = 1'b0;
            @(negedge clk);
        end
        if8.i_clr = 1'b0;
        n_cmp++;
        if (busy_n != 256) begin
            n_err++; $display("FAIL clr_busy_len: busy cycles=%0d required 256", busy_n);
        end
        n_cmp++;
        if (grants != 0) begin
            n_err++; $display("FAIL clr_no_grant: grants=%0d required 0", grants);
        end
        n_cmp++;
        if ({if8.o_count, ram_addr8} !== {9'd0, 8'd0}) begin
            n_err++; $display("FAIL clr_count: count=%0d wptr=%0d required 0", if8.o_count, ram_addr8);
        end
        for (int a = 0; a < 256; a++) if (mem8[a] !== 8'h00) nz++;
        n_cmp++;
        if (nz != 0) begin
            n_err++; $display("FAIL clr_ram_zero: nonzero locations=%0d required 0", nz);
        end
        mw8 = 8'h00; mc8 = 0;
        for (int a = 0; a < 256; a++) m8[a] = 8'h00;
        @(posedge clk); #1;
        rd8(8'd0, "clr_rd_err");
    endtask

    task automatic test_reset_mid_clear();
        wr8(8'h44); wr8(8'h55);
        if8.i_clr = 1'b1;
        @(posedge clk); #1; if8.i_clr = 1'b0;
        repeat (10) @(posedge clk);
        #3; rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({if8.o_busy, if8.o_count, if8.o_rd_valid, if8.o_rd_err, ram_rw8, ram_addr8} !==
            {1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL rst_mid_clear: busy=%b count=%0d rv=%b re=%b rw=%b addr=%h required all zero",
                     if8.o_busy, if8.o_count, if8.o_rd_valid, if8.o_rd_err, ram_rw8, ram_addr8);
        end
        @(negedge clk); rst_n = 1'b1;
        mw8 = 8'h00; mc8 = 0;
        @(posedge clk); #1;
        if8.i_wr_valid = 1'b1; if8.i_wr_data = 8'h5A;
        @(negedge clk);
        n_cmp++;
        if ({if8.o_wr_ready, ram_rw8, ram_addr8} !== {1'b1, 1'b1, 8'd0}) begin
            n_err++;
            $display("FAIL rst_next_write: ready=%b rw=%b addr=%0d required 1 1 0",
                     if8.o_wr_ready, ram_rw8, ram_addr8);
        end
        if (if8.o_wr_ready) begin m8[mw8] = 8'h5A; mw8 = mw8 + 8'd1; mc8++; end
        @(posedge clk); #1; if8.i_wr_valid = 1'b0;
        rd8(8'd0, "rst_rd_back");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bad_offset();
        test_back_to_back();
        test_wrap();
        test_clear();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
